// File: rtl/mantle_concat_pkg.sv
// mantle_concat_pkg
//   Shared definitions for the mantle concat stream blocks.
//   - DEFAULT_WIDTH : default word width in bits
//   - seg_state_e   : which input segment is currently being sourced
//   - frame_len     : number of words in one concatenated frame
package mantle_concat_pkg;

  localparam int DEFAULT_WIDTH = 32;

  typedef enum logic {
    SEG0 = 1'b0,
    SEG1 = 1'b1
  } seg_state_e;

  function automatic int frame_len(input int n0, input int n1);
    return n0 + n1;
  endfunction

endpackage

// File: rtl/mantle_out_reg.sv
// mantle_out_reg
//   Single-entry valid/ready output register carrying a data word and its
//   frame index. A new word may be loaded whenever slot_free is high; the
//   loading logic is expected to respect that.
// Ports:
//   clk, arst           rising-edge clock, asynchronous active-high reset
//   load                capture load_data/load_idx this cycle
//   load_data/load_idx  payload to capture
//   out_ready           downstream accepts the held word
//   out_data/out_idx    registered payload
//   out_valid           payload is valid
//   slot_free           register is empty or draining this cycle
module mantle_out_reg #(
  parameter int WIDTH = 32,
  parameter int IDXW  = 4
) (
  input  logic             clk,
  input  logic             arst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic [IDXW-1:0]  load_idx,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  output logic [IDXW-1:0]  out_idx,
  output logic             slot_free
);

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [IDXW-1:0]  idx_q, idx_d;

  // A load wins over a drain, so a simultaneous drain+load keeps valid high
  // and refreshes the payload with no bubble.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    idx_d   = idx_q;
    if (load) begin
      valid_d = 1'b1;
      data_d  = load_data;
      idx_d   = load_idx;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      idx_q   <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      idx_q   <= idx_d;
    end
  end

  assign out_data  = data_q;
  assign out_valid = valid_q;
  assign out_idx   = idx_q;
  assign slot_free = !valid_q || out_ready;

endmodule

// File: rtl/mantle_concat_stream.sv
// mantle_concat_stream
//   Streams N0 words from in0 followed by N1 words from in1 as one
//   N0+N1-word frame on a single registered valid/ready output, strictly in
//   segment order. Words offered on the inactive input wait untouched.
// Ports:
//   clk, arst                       clock, asynchronous active-high reset
//   in0_data/in0_valid/in0_ready    segment-0 source
//   in1_data/in1_valid/in1_ready    segment-1 source
//   out_data/out_valid/out_ready    frame word output
//   out_idx                         position of out_data within the frame
//   frame_done                      last frame word accepted downstream
//   err (optional)                  sticky order-violation flag
// Optional feature macro: MANTLE_CONCAT_STREAM_ORDER_CHECK_EN
//   Adds the err port, set when in1_valid stays high in SEG0 for more than
//   N0 consecutive cycles without progress on in0.
module mantle_concat_stream
  import mantle_concat_pkg::*;
#(
  parameter  int WIDTH = DEFAULT_WIDTH,
  parameter  int N0    = 9,
  parameter  int N1    = 6,
  localparam int IDXW  = $clog2(frame_len(N0, N1))
) (
  input  logic             clk,
  input  logic             arst,
  input  logic [WIDTH-1:0] in0_data,
  input  logic             in0_valid,
  output logic             in0_ready,
  input  logic [WIDTH-1:0] in1_data,
  input  logic             in1_valid,
  output logic             in1_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDXW-1:0]  out_idx,
  output logic             frame_done
`ifdef MANTLE_CONCAT_STREAM_ORDER_CHECK_EN
  ,
  output logic             err
`endif
);

  localparam int FRAME = frame_len(N0, N1);
  localparam int CMAX  = (N0 > N1) ? N0 : N1;
  localparam int CNTW  = (CMAX > 1) ? $clog2(CMAX) : 1;

  localparam logic [CNTW-1:0] CNT_LAST0 = CNTW'(N0 - 1);
  localparam logic [CNTW-1:0] CNT_LAST1 = CNTW'(N1 - 1);
  localparam logic [IDXW-1:0] IDX_BASE1 = IDXW'(N0);
  localparam logic [IDXW-1:0] IDX_LAST  = IDXW'(FRAME - 1);

  seg_state_e       state_q, state_d;
  logic [CNTW-1:0]  cnt_q, cnt_d;
  logic             slot_free;
  logic             accept;
  logic [WIDTH-1:0] load_data;
  logic [IDXW-1:0]  load_idx;

  // State register: segment selector and per-segment word counter.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_q <= SEG0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: advance the counter on each accept and switch segments on
  // the last word of each segment; SEG1 wraps straight into the next frame.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (accept) begin
      unique case (state_q)
        SEG0: begin
          if (cnt_q == CNT_LAST0) begin
            cnt_d   = '0;
            state_d = SEG1;
          end else begin
            cnt_d = cnt_q + CNTW'(1);
          end
        end
        SEG1: begin
          if (cnt_q == CNT_LAST1) begin
            cnt_d   = '0;
            state_d = SEG0;
          end else begin
            cnt_d = cnt_q + CNTW'(1);
          end
        end
        default: begin
          cnt_d   = '0;
          state_d = SEG0;
        end
      endcase
    end
  end

  // Outputs: readies depend only on state and the output register (never on
  // the valids), and are forced low while reset is asserted.
  always_comb begin
    in0_ready = 1'b0;
    in1_ready = 1'b0;
    accept    = 1'b0;
    load_data = in0_data;
    load_idx  = IDXW'(cnt_q);
    if (!arst) begin
      unique case (state_q)
        SEG0: begin
          in0_ready = slot_free;
          accept    = in0_valid && slot_free;
          load_data = in0_data;
          load_idx  = IDXW'(cnt_q);
        end
        SEG1: begin
          in1_ready = slot_free;
          accept    = in1_valid && slot_free;
          load_data = in1_data;
          load_idx  = IDX_BASE1 + IDXW'(cnt_q);
        end
        default: begin
          accept = 1'b0;
        end
      endcase
    end
  end

  mantle_out_reg #(
    .WIDTH (WIDTH),
    .IDXW  (IDXW)
  ) u_out_reg (
    .clk       (clk),
    .arst      (arst),
    .load      (accept),
    .load_data (load_data),
    .load_idx  (load_idx),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_idx   (out_idx),
    .slot_free (slot_free)
  );

  assign frame_done = out_valid && out_ready && (out_idx == IDX_LAST);

`ifdef MANTLE_CONCAT_STREAM_ORDER_CHECK_EN
  localparam int SW = $clog2(N0 + 1) + 1;
  localparam logic [SW-1:0] STALL_MAX = '1;
  localparam logic [SW-1:0] STALL_LIM = SW'(N0);

  logic [SW-1:0] stall_q, stall_d;
  logic          err_q, err_d;

  // Stall counter tracks consecutive SEG0 cycles with in1 waiting and no
  // in0 progress; crossing N0 such cycles latches err until reset.
  always_comb begin
    stall_d = stall_q;
    err_d   = err_q;
    if ((state_q == SEG0 && accept) || (state_d != state_q)) begin
      stall_d = '0;
    end else if (state_q == SEG0 && in1_valid) begin
      if (stall_q >= STALL_LIM) begin
        err_d = 1'b1;
      end
      if (stall_q != STALL_MAX) begin
        stall_d = stall_q + SW'(1);
      end
    end else begin
      stall_d = '0;
    end
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      stall_q <= '0;
      err_q   <= 1'b0;
    end else begin
      stall_q <= stall_d;
      err_q   <= err_d;
    end
  end

  assign err = err_q;
`endif

endmodule

// File: tb/tb_mantle_concat_stream.sv
// tb_mantle_concat_stream
//   Self-checking bench for mantle_concat_stream (N0=9, N1=6, WIDTH=32).
//   The reference model is a list of expected frame words built directly
//   from the two producers' word lists: N0 from in0, then N1 from in1,
//   frame after frame. A negedge monitor scores every output transfer.
//   Builds with or without MANTLE_CONCAT_STREAM_ORDER_CHECK_EN.
module tb_mantle_concat_stream;

  localparam int WIDTH = 32;
  localparam int N0    = 9;
  localparam int N1    = 6;
  localparam int FRAME = N0 + N1;
  localparam int IDXW  = $clog2(FRAME);

  typedef struct {
    logic [WIDTH-1:0] data;
    logic [IDXW-1:0]  idx;
  } exp_t;

  logic             clk = 1'b0;
  logic             arst;
  logic [WIDTH-1:0] in0_data, in1_data;
  logic             in0_valid, in1_valid;
  logic             in0_ready, in1_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_valid, out_ready;
  logic [IDXW-1:0]  out_idx;
  logic             frame_done;
`ifdef MANTLE_CONCAT_STREAM_ORDER_CHECK_EN
  logic             err;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  logic [WIDTH-1:0] src0_q[$];
  logic [WIDTH-1:0] src1_q[$];
  exp_t             exp_q[$];
  int               fd_cyc_q[$];
  int               xfer_cyc_q[$];
  int               cyc  = 0;
  int               acc0 = 0;
  int               acc1 = 0;

  mantle_concat_stream #(
    .WIDTH (WIDTH),
    .N0    (N0),
    .N1    (N1)
  ) dut (
    .clk        (clk),
    .arst       (arst),
    .in0_data   (in0_data),
    .in0_valid  (in0_valid),
    .in0_ready  (in0_ready),
    .in1_data   (in1_data),
    .in1_valid  (in1_valid),
    .in1_ready  (in1_ready),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_idx    (out_idx),
    .frame_done (frame_done)
`ifdef MANTLE_CONCAT_STREAM_ORDER_CHECK_EN
    ,
    .err        (err)
`endif
  );

  always #5 clk = ~clk;

  // Monitor: inputs change only just after posedge, so the negedge view is
  // what the next posedge will act on.
  logic             hold_prev = 1'b0;
  logic [WIDTH-1:0] hold_data;
  logic [IDXW-1:0]  hold_idx;
  exp_t             mon_e;
  logic             mon_fd_exp;

  always @(negedge clk) begin
    if (arst) begin
      hold_prev = 1'b0;
    end else begin
      cyc++;
      n_cmp++;
      if (in0_ready && in1_ready) begin
        n_fail++;
        $display("[TB] FAIL both_ready: in0_ready=%b in1_ready=%b, required not both 1", in0_ready, in1_ready);
      end
      if (hold_prev) begin
        n_cmp++;
        if (out_valid !== 1'b1 || out_data !== hold_data || out_idx !== hold_idx) begin
          n_fail++;
          $display("[TB] FAIL hold_stable: valid=%b data=%h idx=%0d, required valid=1 data=%h idx=%0d",
                   out_valid, out_data, out_idx, hold_data, hold_idx);
        end
      end
      hold_prev = out_valid && !out_ready;
      hold_data = out_data;
      hold_idx  = out_idx;
      if (out_valid && out_ready) begin
        xfer_cyc_q.push_back(cyc);
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("[TB] FAIL unexpected_word: data=%h idx=%0d, required no transfer", out_data, out_idx);
        end else begin
          mon_e = exp_q.pop_front();
          if (out_data !== mon_e.data || out_idx !== mon_e.idx) begin
            n_fail++;
            $display("[TB] FAIL out_word: data=%h idx=%0d, required data=%h idx=%0d",
                     out_data, out_idx, mon_e.data, mon_e.idx);
          end
          mon_fd_exp = (int'(mon_e.idx) == FRAME - 1);
          n_cmp++;
          if (frame_done !== mon_fd_exp) begin
            n_fail++;
            $display("[TB] FAIL frame_done: got %b, required %b at idx %0d", frame_done, mon_fd_exp, mon_e.idx);
          end
        end
        if (frame_done === 1'b1) fd_cyc_q.push_back(cyc);
      end else begin
        n_cmp++;
        if (frame_done !== 1'b0) begin
          n_fail++;
          $display("[TB] FAIL frame_done_idle: got %b, required 0", frame_done);
        end
      end
      if (in0_valid && in0_ready) begin
        acc0++;
        if (src0_q.size() > 0) void'(src0_q.pop_front());
      end
      if (in1_valid && in1_ready) begin
        acc1++;
        if (src1_q.size() > 0) void'(src1_q.pop_front());
      end
    end
  end

  // Fill both producers and the expected frame stream.
  task automatic load_frames(input int nf, input bit pattern);
    logic [WIDTH-1:0] w;
    exp_t e;
    for (int f = 0; f < nf; f++) begin
      for (int i = 0; i < N0; i++) begin
        w = pattern ? WIDTH'(32'h100 + i) : WIDTH'($urandom);
        src0_q.push_back(w);
        e.data = w;
        e.idx  = IDXW'(i);
        exp_q.push_back(e);
      end
      for (int j = 0; j < N1; j++) begin
        w = pattern ? WIDTH'(32'h200 + j) : WIDTH'($urandom);
        src1_q.push_back(w);
        e.data = w;
        e.idx  = IDXW'(N0 + j);
        exp_q.push_back(e);
      end
    end
  endtask

  // One clock of stimulus: each producer offers its head word with the given
  // percentage, downstream accepts with percentage pr.
  task automatic drive_cycle(input int p0, input int p1, input int pr);
    in0_valid = (src0_q.size() > 0) && (int'($urandom_range(99)) < p0);
    in0_data  = (src0_q.size() > 0) ? src0_q[0] : WIDTH'($urandom);
    in1_valid = (src1_q.size() > 0) && (int'($urandom_range(99)) < p1);
    in1_data  = (src1_q.size() > 0) ? src1_q[0] : WIDTH'($urandom);
    out_ready = int'($urandom_range(99)) < pr;
    @(posedge clk);
    #1;
  endtask

  task automatic run_until_empty(input int p0, input int p1, input int pr, input string name);
    int budget = 3000;
    while (exp_q.size() > 0 && budget > 0) begin
      drive_cycle(p0, p1, pr);
      budget--;
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("[TB] FAIL %s_drain: %0d words outstanding, required 0", name, exp_q.size());
    end
    in0_valid = 1'b0;
    in1_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    arst      = 1'b1;
    in0_valid = 1'b1;
    in1_valid = 1'b1;
    in0_data  = '0;
    in1_data  = '0;
    out_ready = 1'b1;
    #2;
    n_cmp += 6;
    if (out_valid !== 1'b0)  begin n_fail++; $display("[TB] FAIL rst_valid: got %b, required 0", out_valid); end
    if (out_data !== '0)     begin n_fail++; $display("[TB] FAIL rst_data: got %h, required 0", out_data); end
    if (out_idx !== '0)      begin n_fail++; $display("[TB] FAIL rst_idx: got %0d, required 0", out_idx); end
    if (frame_done !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_done: got %b, required 0", frame_done); end
    if (in0_ready !== 1'b0)  begin n_fail++; $display("[TB] FAIL rst_in0_ready: got %b, required 0", in0_ready); end
    if (in1_ready !== 1'b0)  begin n_fail++; $display("[TB] FAIL rst_in1_ready: got %b, required 0", in1_ready); end
    in0_valid = 1'b0;
    in1_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    arst = 1'b0;
    #1;
    n_cmp++;
    if (in0_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL post_rst_in0_ready: got %b, required 1", in0_ready); end
  endtask

  task automatic test_basic_frame();
    $display("[TB] basic frame");
    load_frames(1, 1'b1);
    xfer_cyc_q.delete();
    fd_cyc_q.delete();
    drive_cycle(100, 100, 100);
    n_cmp++;
    if (out_valid !== 1'b1 || out_idx !== '0 || out_data !== 32'h100) begin
      n_fail++;
      $display("[TB] FAIL basic_latency: valid=%b idx=%0d data=%h, required 1/0/00000100", out_valid, out_idx, out_data);
    end
    run_until_empty(100, 100, 100, "basic");
    n_cmp++;
    if (xfer_cyc_q.size() != FRAME || (xfer_cyc_q[FRAME-1] - xfer_cyc_q[0]) != FRAME - 1) begin
      n_fail++;
      $display("[TB] FAIL basic_gapless: %0d transfers, required %0d consecutive", xfer_cyc_q.size(), FRAME);
    end
    n_cmp++;
    if (fd_cyc_q.size() != 1 || fd_cyc_q[0] != xfer_cyc_q[xfer_cyc_q.size()-1]) begin
      n_fail++;
      $display("[TB] FAIL basic_done_count: %0d pulses, required 1 on the last word", fd_cyc_q.size());
    end
  endtask

  task automatic test_ordering();
    logic exp_r1;
    int   k = 0;
    $display("[TB] ordering");
    load_frames(1, 1'b0);
    acc0 = 0;
    acc1 = 0;
    while (exp_q.size() > 0 && k < 400) begin
      drive_cycle(((k % 3) == 0) ? 100 : 0, 100, 100);
      k++;
      exp_r1 = (acc0 == N0) && (acc1 < N1);
      n_cmp++;
      if (in1_ready !== exp_r1) begin
        n_fail++;
        $display("[TB] FAIL order_in1_ready: got %b, required %b after %0d in0 accepts", in1_ready, exp_r1, acc0);
      end
    end
    run_until_empty(100, 100, 100, "ordering");
  endtask

  task automatic test_backpressure();
    logic [WIDTH-1:0] held;
    int k = 0;
    $display("[TB] backpressure");
    load_frames(1, 1'b0);
    while (!(out_valid === 1'b1 && out_idx === IDXW'(4)) && k < 100) begin
      drive_cycle(100, 100, 100);
      k++;
    end
    n_cmp++;
    if (!(out_valid === 1'b1 && out_idx === IDXW'(4))) begin
      n_fail++;
      $display("[TB] FAIL bp_reach_idx4: idx=%0d valid=%b, required idx 4 valid", out_idx, out_valid);
    end
    held = exp_q[0].data;
    for (int c = 0; c < 5; c++) begin
      drive_cycle(100, 100, 0);
      n_cmp += 2;
      if (out_valid !== 1'b1 || out_data !== held || out_idx !== IDXW'(4)) begin
        n_fail++;
        $display("[TB] FAIL bp_hold: valid=%b data=%h idx=%0d, required 1/%h/4", out_valid, out_data, out_idx, held);
      end
      if (in0_ready !== 1'b0 || in1_ready !== 1'b0) begin
        n_fail++;
        $display("[TB] FAIL bp_ready: in0=%b in1=%b, required 0/0", in0_ready, in1_ready);
      end
    end
    run_until_empty(100, 100, 100, "backpressure");
  endtask

  task automatic test_back_to_back();
    $display("[TB] back to back");
    load_frames(3, 1'b0);
    fd_cyc_q.delete();
    run_until_empty(100, 100, 100, "b2b");
    n_cmp++;
    if (fd_cyc_q.size() != 3) begin
      n_fail++;
      $display("[TB] FAIL b2b_done_count: got %0d pulses, required 3", fd_cyc_q.size());
    end else begin
      n_cmp++;
      if ((fd_cyc_q[1] - fd_cyc_q[0]) != FRAME || (fd_cyc_q[2] - fd_cyc_q[1]) != FRAME) begin
        n_fail++;
        $display("[TB] FAIL b2b_spacing: got %0d and %0d cycles, required %0d", fd_cyc_q[1] - fd_cyc_q[0],
                 fd_cyc_q[2] - fd_cyc_q[1], FRAME);
      end
    end
  endtask

  task automatic test_random();
    $display("[TB] random traffic");
    load_frames(4, 1'b0);
    run_until_empty(60, 60, 70, "random");
  endtask

  task automatic test_reset_mid();
    logic [WIDTH-1:0] first;
    int k = 0;
    $display("[TB] reset mid-frame");
    load_frames(1, 1'b0);
    while (!(out_valid === 1'b1 && out_idx === IDXW'(11)) && k < 100) begin
      drive_cycle(100, 100, 100);
      k++;
    end
    n_cmp++;
    if (!(out_valid === 1'b1 && out_idx === IDXW'(11))) begin
      n_fail++;
      $display("[TB] FAIL rm_reach_idx11: idx=%0d valid=%b, required idx 11 valid", out_idx, out_valid);
    end
    in0_valid = 1'b0;
    in1_valid = 1'b0;
    arst      = 1'b1;
    #1;
    n_cmp += 2;
    if (out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL rm_async_valid: got %b, required 0", out_valid); end
    if (out_idx !== '0)     begin n_fail++; $display("[TB] FAIL rm_async_idx: got %0d, required 0", out_idx); end
    src0_q.delete();
    src1_q.delete();
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    arst = 1'b0;
    load_frames(1, 1'b0);
    first = exp_q[0].data;
    drive_cycle(100, 100, 100);
    n_cmp++;
    if (out_valid !== 1'b1 || out_idx !== '0 || out_data !== first) begin
      n_fail++;
      $display("[TB] FAIL rm_first_word: valid=%b idx=%0d data=%h, required 1/0/%h", out_valid, out_idx, out_data, first);
    end
    run_until_empty(100, 100, 100, "reset_mid");
  endtask

`ifdef MANTLE_CONCAT_STREAM_ORDER_CHECK_EN
  task automatic test_order_check();
    logic exp_err;
    $display("[TB] order check");
    arst = 1'b1;
    @(posedge clk);
    #1;
    arst = 1'b0;
    n_cmp++;
    if (err !== 1'b0) begin n_fail++; $display("[TB] FAIL err_after_reset: got %b, required 0", err); end
    in0_valid = 1'b0;
    in1_valid = 1'b1;
    out_ready = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      @(posedge clk);
      #1;
      exp_err = (c >= 10);
      n_cmp++;
      if (err !== exp_err) begin
        n_fail++;
        $display("[TB] FAIL err_cycle%0d: got %b, required %b", c, err, exp_err);
      end
    end
    in1_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (err !== 1'b1) begin n_fail++; $display("[TB] FAIL err_sticky: got %b, required 1", err); end
    arst = 1'b1;
    #1;
    n_cmp++;
    if (err !== 1'b0) begin n_fail++; $display("[TB] FAIL err_clear: got %b, required 0", err); end
    @(posedge clk);
    #1;
    arst = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_basic_frame();
    test_ordering();
    test_backpressure();
    test_back_to_back();
    test_random();
    test_reset_mid();
`ifdef MANTLE_CONCAT_STREAM_ORDER_CHECK_EN
    test_order_check();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
